serial_pattern_gen: RTL and testbench
=====================================

Name: serial_pattern_gen

Overview:
- Serial bit-stream transmitter that drives the `x_in` input of the team's consecutive-ones sequence detectors.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on `x_out`, one bit per clock.
- Inserts a programmable run of zero bits between words.
- Tracks the consecutive-ones run on its own output, so benches and the system can cross-check the downstream detector.

Parameters:
- WIDTH, 8: bits per word; must be at least 2.
- GAP_CYCLES, 1: zero bits forced onto `x_out` after each word; 0 means seamless back-to-back words.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- data_in  input  WIDTH  parallel word, MSB transmitted first
- valid_in  input  1  data_in is valid
- ready_out  output  1  block can accept a word this cycle
- x_out  output  1  registered serial bit stream
- busy  output  1  a word or gap is in progress
- word_done  output  1  one-cycle pulse after the last bit of a word
- ones_run  output  2  saturating count (0..3) of consecutive 1s on x_out, including the current bit
- run_hit  output  1  ones_run == 3

Behaviour:
- Reset is asynchronous, active-low, on rstn, with one clock clk.
- Reset values: state IDLE, x_out 0, ready_out 1, busy 0, word_done 0, ones_run 0, run_hit 0, shift register 0, counters 0.
- Reset mid-word takes effect immediately. The word in flight is dropped and not resumed.
- States are IDLE, SHIFT and GAP.
- IDLE:
  - ready_out = 1, busy = 0, x_out held 0.
  - An accept occurs on a rising edge where valid_in and ready_out are both 1.
  - On accept: load data_in into the shift register, bit counter = 0, x_out <= data_in[WIDTH-1], go to SHIFT.
  - data_in and valid_in are ignored whenever ready_out = 0.
- SHIFT:
  - Latency: the accept edge makes bit WIDTH-1 visible in cycle C1. Bit WIDTH-1-k is visible in cycle C(k+1), up to C(WIDTH).
  - busy = 1.
  - At the edge ending C(WIDTH), the block pulses word_done = 1 for cycle C(WIDTH+1). If GAP_CYCLES > 0 it goes to GAP with x_out <= 0; otherwise it goes to IDLE with x_out <= 0.
- GAP_CYCLES = 0 (seamless mode):
  - ready_out is also 1 during C(WIDTH).
  - An accept at that edge loads the next word directly: x_out <= new MSB, state stays SHIFT, counter = 0.
  - The stream then has no zero between words. word_done still pulses.
- GAP:
  - x_out = 0, busy = 1, ready_out = 0.
  - The gap counter runs for GAP_CYCLES cycles, then the block returns to IDLE.
  - With GAP = 1: gap bit in C(WIDTH+1), ready_out = 1 from C(WIDTH+2).
- ones_run:
  - Updated on the same edge as x_out, from the new x_out value: next = (new x_out ? min(ones_run+1, 3) : 0).
  - It saturates at 3 and never wraps.
  - It therefore equals the downstream detector's state for the bit currently on x_out.
- run_hit is combinational from ones_run (== 3).
- Bit counter width is clog2(WIDTH). The gap counter width is clog2(GAP_CYCLES+1), with a minimum of 1.
- Simultaneous events:
  - Reset dominates all.
  - In seamless mode, word_done for the old word and the load of the new word occur on the same edge.
- valid_in held high continuously: a new word is accepted every time ready_out is 1. The upstream producer must update data_in on each accept.

Decomposition:
- Shared package `serial_pkg`:
  - state encoding constants IDLE = 2'b00, SHIFT = 2'b01, GAP = 2'b10;
  - a ones-run saturation constant RUN_MAX = 3, shared with the detector.
- One natural sub-module, `ones_run_tracker`: the 2-bit saturating run counter plus run_hit. It is reusable on the receive side for a reference model.
- The shifter and FSM stay in the top module.

Test Plan:
- Reset then idle 5 cycles, valid_in = 0 -> x_out 0, ready_out 1, busy 0, ones_run 0 throughout.
- WIDTH = 8, GAP = 1, send 8'hE5:
  - x_out on C1..C8 = 1,1,1,0,0,1,0,1 and ones_run = 1,2,3,0,0,1,0,1;
  - run_hit only in C3;
  - C9: x_out 0, word_done 1; ready_out 1 from C10.
- GAP = 0, two accepts of 8'hFF back-to-back -> 16 consecutive 1s with no zero between words, ready_out = 1 in C8, ones_run saturates at 3 from C3 to C16, word_done in C9 and C17.
- GAP = 1, two 8'hFF words -> C9 x_out = 0, ones_run 0; second word's C1..C3 gives ones_run 1,2,3.
- rstn low in C4 of 8'hE5 -> x_out 0, ready_out 1, ones_run 0 immediately, no word_done. A subsequent 8'h81 transmits as 1,0,0,0,0,0,0,1.
- valid_in high with data_in changing every cycle during SHIFT -> only the word present at the accept edge is transmitted. The next accept happens only when ready_out returns to 1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern generator and the consecutive-ones detectors.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_e;

    localparam logic [1:0] RUN_MAX = 2'd3;

    // Saturating consecutive-ones update for one incoming bit.
    function automatic logic [1:0] run_next(input logic [1:0] run, input logic bit_v);
        logic [1:0] nxt;
        if (!bit_v) begin
            nxt = 2'd0;
        end else if (run == RUN_MAX) begin
            nxt = RUN_MAX;
        end else begin
            nxt = run + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ones_run_tracker.sv
// Saturating count of consecutive ones on a serial stream, fed with the bit about to be registered.
module ones_run_tracker
    import serial_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       bit_i,
    output logic [1:0] run_o,
    output logic       run_hit_o
);

    logic [1:0] run_q;
    logic [1:0] run_d;

    // Next run length from the incoming bit.
    always_comb begin
        run_d = run_next(run_q, bit_i);
    end

    // Run length register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q <= 2'd0;
        end else begin
            run_q <= run_d;
        end
    end

    assign run_o     = run_q;
    assign run_hit_o = (run_q == RUN_MAX);

endmodule

// File: rtl/serial_pattern_gen.sv
// MSB-first serial transmitter with valid/ready word input, programmable zero gap and ones-run tracking.
module serial_pattern_gen
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             x_out,
    output logic             busy,
    output logic             word_done,
    output logic [1:0]       ones_run,
    output logic             run_hit
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : GW'(0);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              x_q, x_d;
    logic              done_q, done_d;
    logic              ready_s;
    logic              accept_s;

    // Seamless mode also opens the handshake during the last bit of a word.
    assign ready_s  = (state_q == IDLE) ||
                      ((GAP_CYCLES == 0) && (state_q == SHIFT) && (bit_cnt_q == BIT_LAST));
    assign accept_s = valid_in && ready_s;

    // Next-state, shifter and counter logic.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        x_d       = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shreg_d   = data_in;
                    bit_cnt_d = BW'(0);
                    x_d       = data_in[WIDTH-1];
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    done_d = 1'b1;
                    if (accept_s) begin
                        shreg_d   = data_in;
                        bit_cnt_d = BW'(0);
                        x_d       = data_in[WIDTH-1];
                        state_d   = SHIFT;
                    end else if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GW'(0);
                        state_d   = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    x_d       = shreg_q[WIDTH-2];
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = GW'(0);
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            shreg_q   <= {WIDTH{1'b0}};
            bit_cnt_q <= BW'(0);
            gap_cnt_q <= GW'(0);
            x_q       <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            done_q    <= done_d;
        end
    end

    ones_run_tracker u_run (
        .clk       (clk),
        .rstn      (rstn),
        .bit_i     (x_d),
        .run_o     (ones_run),
        .run_hit_o (run_hit)
    );

    assign ready_out = ready_s;
    assign x_out     = x_q;
    assign busy      = (state_q != IDLE);
    assign word_done = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench: a future-timeline model predicts every cycle of two generators (gap 0 and gap 1).
module tb_serial_pattern_gen;

    localparam int W = 8;
    localparam int L = 16;

    typedef struct packed {
        logic       x;
        logic       done;
        logic       busy;
        logic       ready;
        logic [1:0] run;
    } exp_t;

    logic         clk = 1'b1;
    logic         rstn;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         rdy_s  [2];
    logic         x_s    [2];
    logic         busy_s [2];
    logic         done_s [2];
    logic         hit_s  [2];
    logic [1:0]   run_s  [2];

    serial_pattern_gen #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .data_in(data_in), .valid_in(valid_in),
        .ready_out(rdy_s[0]), .x_out(x_s[0]), .busy(busy_s[0]), .word_done(done_s[0]),
        .ones_run(run_s[0]), .run_hit(hit_s[0])
    );

    serial_pattern_gen #(.WIDTH(W), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rstn(rstn), .data_in(data_in), .valid_in(valid_in),
        .ready_out(rdy_s[1]), .x_out(x_s[1]), .busy(busy_s[1]), .word_done(done_s[1]),
        .ones_run(run_s[1]), .run_hit(hit_s[1])
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];
    // Timeline per DUT: index 0 is the cycle currently on the outputs.
    logic fx    [2][L];
    logic fdone [2][L];
    logic fbusy [2][L];
    logic fready[2][L];
    int   run_m [2];
    bit   mon_en = 1'b0;

    task automatic clear_g(input int g);
        for (int k = 0; k < L; k++) begin
            fx[g][k] = 1'b0; fdone[g][k] = 1'b0; fbusy[g][k] = 1'b0; fready[g][k] = 1'b1;
        end
        run_m[g] = 0;
    endtask

    function automatic exp_t cur_rec(input int g);
        exp_t r;
        r.x = fx[g][0]; r.done = fdone[g][0]; r.busy = fbusy[g][0]; r.ready = fready[g][0];
        r.run = 2'(run_m[g]);
        return r;
    endfunction

    task automatic push(input int g, input exp_t r);
        if (g == 0) sbq0.push_back(r);
        else        sbq1.push_back(r);
    endtask

    // Advance the model across the coming clock edge; DUT g uses GAP_CYCLES = g.
    task automatic step();
        for (int g = 0; g < 2; g++) begin
            logic acc;
            acc = rstn && valid_in && fready[g][0];
            if (!rstn) begin
                clear_g(g);
            end else begin
                for (int k = 0; k < L - 1; k++) begin
                    fx[g][k] = fx[g][k+1]; fdone[g][k] = fdone[g][k+1];
                    fbusy[g][k] = fbusy[g][k+1]; fready[g][k] = fready[g][k+1];
                end
                fx[g][L-1] = 1'b0; fdone[g][L-1] = 1'b0; fbusy[g][L-1] = 1'b0; fready[g][L-1] = 1'b1;
                if (acc) begin
                    for (int k = 0; k < W + g; k++) begin
                        fbusy[g][k] = 1'b1;
                        if (k < W) begin
                            fx[g][k]    = data_in[W-1-k];
                            fready[g][k] = (g == 0) && (k == W - 1);
                        end else begin
                            fx[g][k]    = 1'b0;
                            fready[g][k] = 1'b0;
                        end
                    end
                    fdone[g][W] = 1'b1;
                end
                run_m[g] = fx[g][0] ? ((run_m[g] < 3) ? run_m[g] + 1 : 3) : 0;
            end
            push(g, cur_rec(g));
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d);
        valid_in = v;
        data_in  = d;
        step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle: expectations restart from reset values at once.
    task automatic do_reset(input int hold);
        rstn     = 1'b0;
        valid_in = 1'b0;
        sbq0.delete();
        sbq1.delete();
        clear_g(0);
        clear_g(1);
        push(0, cur_rec(0));
        push(1, cur_rec(1));
        repeat (hold) begin
            step();
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
    endtask

    task automatic chk(input string nm, input int g, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", nm, g, act, req, $time);
        end
    endtask

    // Monitor: one expected record per DUT per cycle, compared on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t r;
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                if (((g == 0) ? sbq0.size() : sbq1.size()) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty dut%0d actual=0 required=1 at %0t", g, $time);
                end else begin
                    r = (g == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    chk("x_out",     g, {1'b0, x_s[g]},    {1'b0, r.x});
                    chk("ready_out", g, {1'b0, rdy_s[g]},  {1'b0, r.ready});
                    chk("busy",      g, {1'b0, busy_s[g]}, {1'b0, r.busy});
                    chk("word_done", g, {1'b0, done_s[g]}, {1'b0, r.done});
                    chk("ones_run",  g, run_s[g],          r.run);
                    chk("run_hit",   g, {1'b0, hit_s[g]},  {1'b0, (r.run == 2'd3)});
                end
            end
        end
    end

    initial begin
        rstn     = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        clear_g(0);
        clear_g(1);
        push(0, cur_rec(0));
        push(1, cur_rec(1));
        mon_en = 1'b1;
        repeat (3) cyc(1'b0, 8'h00);
        rstn = 1'b1;
        repeat (5) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hE5);
        repeat (12) cyc(1'b0, 8'h00);
        repeat (18) cyc(1'b1, 8'hFF);
        repeat (12) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hE5);
        repeat (3) cyc(1'b0, 8'h00);
        do_reset(2);
        repeat (2) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h81);
        repeat (12) cyc(1'b0, 8'h00);
        repeat (60) cyc(1'b1, 8'($urandom));
        repeat (400) begin
            if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 3)));
            else cyc($urandom_range(0, 3) != 0, 8'($urandom));
        end
        repeat (12) cyc(1'b0, 8'h00);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        total++;
        if (sbq0.size() + sbq1.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover actual=%0d required=0", sbq0.size() + sbq1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
